// File: rtl/guess_evaluator_if.sv
`default_nettype none
// ============================================================================
// Module      : guess_evaluator_if
// Description : Bundles the board-state request/result signals and the shared
//               board-RAM write port of the guess evaluator.
//               master = board-state logic plus RAM arbiter side.
//               slave  = the evaluator itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface guess_evaluator_if #(
    parameter int PIN_COLOR_W = 5,
    parameter int PIN_POS_W   = 5,
    parameter int MAX_PINS    = 20,
    parameter int RAM_ADDR_W  = 12
);
    // Request and operands from board-state logic
    logic                            start;
    logic [PIN_POS_W-1:0]            pins_count;
    logic [7:0]                      guess_index;
    logic [MAX_PINS*PIN_COLOR_W-1:0] guess;
    logic [MAX_PINS*PIN_COLOR_W-1:0] secret;

    // Status and results
    logic                            busy;
    logic                            done;
    logic                            err;
    logic [PIN_POS_W-1:0]            green;
    logic [PIN_POS_W-1:0]            yellow;
    logic                            win;

    // Board RAM write port (request/grant)
    logic                            ram_req;
    logic                            ram_gnt;
    logic [RAM_ADDR_W-1:0]           ram_addr;
    logic [PIN_COLOR_W-1:0]          ram_wdata;
    logic                            ram_we;

    modport master (
        output start, pins_count, guess_index, guess, secret, ram_gnt,
        input  busy, done, err, green, yellow, win,
               ram_req, ram_addr, ram_wdata, ram_we
    );

    modport slave (
        input  start, pins_count, guess_index, guess, secret, ram_gnt,
        output busy, done, err, green, yellow, win,
               ram_req, ram_addr, ram_wdata, ram_we
    );
endinterface
`default_nettype wire

// File: rtl/guess_evaluator.sv
`default_nettype none
// ============================================================================
// Module      : guess_evaluator
// Description : Scores one guess against the secret (green = right colour and
//               position, yellow = right colour wrong position, one pin
//               comparison per cycle), then uploads the guess pins and both
//               hint counts to the shared board RAM via a request/grant port.
// Revision    : 1.0 - initial release
// ============================================================================
module guess_evaluator #(
    parameter int PIN_COLOR_W  = 5,
    parameter int PIN_POS_W    = 5,
    parameter int MAX_PINS     = 20,
    parameter int MAX_GUESSES  = 99,
    parameter int RAM_ADDR_W   = 12,
    parameter int HINTS_OFFSET = 1980
) (
    input  wire logic         clk,
    input  wire logic         nreset,
    guess_evaluator_if.slave  eval_if
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GREEN    = 3'd1,
        S_YELLOW   = 3'd2,
        S_WR_PINS  = 3'd3,
        S_WR_HINTS = 3'd4,
        S_FINISH   = 3'd5
    } state_t;

    localparam int                   c_vec_w       = MAX_PINS * PIN_COLOR_W;
    localparam logic [PIN_POS_W-1:0] c_max_pins    = PIN_POS_W'(MAX_PINS);
    localparam logic [PIN_POS_W-1:0] c_one         = PIN_POS_W'(1);
    localparam logic [7:0]           c_max_guesses = 8'(MAX_GUESSES);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                 state_q,  state_d;
    logic [c_vec_w-1:0]     guess_q,  guess_d;
    logic [c_vec_w-1:0]     secret_q, secret_d;
    logic [7:0]             row_q,    row_d;
    logic [PIN_POS_W-1:0]   n_q,      n_d;
    logic [PIN_POS_W-1:0]   i_q,      i_d;
    logic [PIN_POS_W-1:0]   j_q,      j_d;
    logic [PIN_POS_W-1:0]   p_q,      p_d;
    logic                   hw_q,     hw_d;      // hint word select: 0 green, 1 yellow
    logic [MAX_PINS-1:0]    ag_q,     ag_d;      // guess pin already matched
    logic [MAX_PINS-1:0]    as_q,     as_d;      // secret pin already consumed
    logic [PIN_POS_W-1:0]   green_q,  green_d;
    logic [PIN_POS_W-1:0]   yellow_q, yellow_d;
    logic                   win_q,    win_d;
    logic                   err_q,    err_d;

    // YELLOW-phase helpers
    logic                   w_adv_i;
    logic                   w_leave_y;
    logic                   w_win_next;

    // RAM port drive
    logic                   w_ram_req;
    logic [RAM_ADDR_W-1:0]  w_ram_addr;
    logic [PIN_COLOR_W-1:0] w_ram_wdata;
    logic [RAM_ADDR_W-1:0]  w_row_base;
    logic [RAM_ADDR_W-1:0]  w_hint_base;

    // Latched pins viewed as arrays so a pin can be picked by a counter
    logic [PIN_COLOR_W-1:0] w_gpin [MAX_PINS];
    logic [PIN_COLOR_W-1:0] w_spin [MAX_PINS];

    generate
        for (genvar k = 0; k < MAX_PINS; k++) begin : g_unpack
            assign w_gpin[k] = guess_q [k*PIN_COLOR_W +: PIN_COLOR_W];
            assign w_spin[k] = secret_q[k*PIN_COLOR_W +: PIN_COLOR_W];
        end
    endgenerate

    assign w_win_next = (green_q == n_q) && (n_q != '0);

    // Next-state and datapath update for the scoring/upload sequence
    always_comb begin
        state_d   = state_q;
        guess_d   = guess_q;
        secret_d  = secret_q;
        row_d     = row_q;
        n_d       = n_q;
        i_d       = i_q;
        j_d       = j_q;
        p_d       = p_q;
        hw_d      = hw_q;
        ag_d      = ag_q;
        as_d      = as_q;
        green_d   = green_q;
        yellow_d  = yellow_q;
        win_d     = win_q;
        err_d     = err_q;
        w_adv_i   = 1'b0;
        w_leave_y = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (eval_if.start) begin
                    guess_d  = eval_if.guess;
                    secret_d = eval_if.secret;
                    row_d    = eval_if.guess_index;
                    n_d      = (eval_if.pins_count > c_max_pins) ? c_max_pins
                                                                 : eval_if.pins_count;
                    i_d      = '0;
                    j_d      = '0;
                    p_d      = '0;
                    hw_d     = 1'b0;
                    ag_d     = '0;
                    as_d     = '0;
                    green_d  = '0;
                    yellow_d = '0;
                    win_d    = 1'b0;
                    err_d    = 1'b0;
                    state_d  = S_GREEN;
                end
            end

            S_GREEN: begin
                if (n_q == '0) begin
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_YELLOW;
                end else begin
                    if (w_gpin[i_q] == w_spin[i_q]) begin
                        green_d    = green_q + c_one;
                        ag_d[i_q]  = 1'b1;
                        as_d[i_q]  = 1'b1;
                    end
                    if (i_q == n_q - c_one) begin
                        i_d     = '0;
                        j_d     = '0;
                        state_d = S_YELLOW;
                    end else begin
                        i_d = i_q + c_one;
                    end
                end
            end

            S_YELLOW: begin
                // Only reachable with i==n when n is zero; otherwise the
                // exit is taken on the same cycle that finishes the last pin.
                if (i_q == n_q) begin
                    w_leave_y = 1'b1;
                end else begin
                    if (ag_q[i_q]) begin
                        w_adv_i = 1'b1;
                    end else if (!as_q[j_q] && (w_gpin[i_q] == w_spin[j_q])) begin
                        yellow_d   = yellow_q + c_one;
                        ag_d[i_q]  = 1'b1;
                        as_d[j_q]  = 1'b1;
                        w_adv_i    = 1'b1;
                    end else if (j_q == n_q - c_one) begin
                        w_adv_i = 1'b1;
                    end else begin
                        j_d = j_q + c_one;
                    end

                    if (w_adv_i) begin
                        i_d = i_q + c_one;
                        j_d = '0;
                        if (i_q + c_one == n_q) begin
                            w_leave_y = 1'b1;
                        end
                    end
                end

                if (w_leave_y) begin
                    i_d   = '0;
                    j_d   = '0;
                    win_d = w_win_next;
                    if (row_q >= c_max_guesses) begin
                        // Row lies outside the board: report and skip the upload
                        err_d   = 1'b1;
                        state_d = S_FINISH;
                    end else if (n_q == '0) begin
                        hw_d    = 1'b0;
                        state_d = S_WR_HINTS;
                    end else begin
                        p_d     = '0;
                        state_d = S_WR_PINS;
                    end
                end
            end

            S_WR_PINS: begin
                if (eval_if.ram_gnt) begin
                    if (p_q == n_q - c_one) begin
                        hw_d    = 1'b0;
                        state_d = S_WR_HINTS;
                    end else begin
                        p_d = p_q + c_one;
                    end
                end
            end

            S_WR_HINTS: begin
                if (eval_if.ram_gnt) begin
                    if (hw_q) begin
                        state_d = S_FINISH;
                    end else begin
                        hw_d = 1'b1;
                    end
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q  <= S_IDLE;
            guess_q  <= '0;
            secret_q <= '0;
            row_q    <= '0;
            n_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            p_q      <= '0;
            hw_q     <= 1'b0;
            ag_q     <= '0;
            as_q     <= '0;
            green_q  <= '0;
            yellow_q <= '0;
            win_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            secret_q <= secret_d;
            row_q    <= row_d;
            n_q      <= n_d;
            i_q      <= i_d;
            j_q      <= j_d;
            p_q      <= p_d;
            hw_q     <= hw_d;
            ag_q     <= ag_d;
            as_q     <= as_d;
            green_q  <= green_d;
            yellow_q <= yellow_d;
            win_q    <= win_d;
            err_q    <= err_d;
        end
    end

    // Address bases: guess rows are MAX_PINS wide, hint rows two words wide
    assign w_row_base  = RAM_ADDR_W'(row_q) * RAM_ADDR_W'(MAX_PINS);
    assign w_hint_base = RAM_ADDR_W'(HINTS_OFFSET) + (RAM_ADDR_W'(row_q) << 1);

    // RAM request, address and data; held stable while the grant is absent
    always_comb begin
        w_ram_req   = 1'b0;
        w_ram_addr  = '0;
        w_ram_wdata = '0;
        case (state_q)
            S_WR_PINS: begin
                w_ram_req   = 1'b1;
                w_ram_addr  = w_row_base + RAM_ADDR_W'(p_q);
                w_ram_wdata = w_gpin[p_q];
            end
            S_WR_HINTS: begin
                w_ram_req   = 1'b1;
                w_ram_addr  = w_hint_base + RAM_ADDR_W'(hw_q);
                w_ram_wdata = hw_q ? PIN_COLOR_W'(yellow_q) : PIN_COLOR_W'(green_q);
            end
            default: begin
                w_ram_req   = 1'b0;
            end
        endcase
    end

    assign eval_if.busy      = (state_q == S_GREEN)   || (state_q == S_YELLOW) ||
                               (state_q == S_WR_PINS) || (state_q == S_WR_HINTS);
    assign eval_if.done      = (state_q == S_FINISH);
    assign eval_if.err       = err_q;
    assign eval_if.green     = green_q;
    assign eval_if.yellow    = yellow_q;
    assign eval_if.win       = win_q;
    assign eval_if.ram_req   = w_ram_req;
    assign eval_if.ram_addr  = w_ram_addr;
    assign eval_if.ram_wdata = w_ram_wdata;
    assign eval_if.ram_we    = w_ram_req & eval_if.ram_gnt;

endmodule
`default_nettype wire
